// File: rtl/doppler_pri_sequencer.sv
// doppler_pri_sequencer: pulsed-Doppler TX burst / RX strobe / range-gate timing core (rev 1.0).
// Optional build macro TX_DEADTIME_EN adds a one-cycle TX non-overlap on every burst transition.
`default_nettype none

module doppler_pri_sequencer #(
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 4,
  parameter int NUM_GATES = 2,
  parameter int PRI_W     = 8
) (
  input  logic                       coreClock,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic                       start,
  input  logic [DIV_W-1:0]           half_div,
  input  logic [CNT_W-1:0]           burst_len,
  input  logic [CNT_W-1:0]           pri_len,
  input  logic [NUM_GATES*CNT_W-1:0] gate_start,
  input  logic [NUM_GATES*CNT_W-1:0] gate_len,
  input  logic [PRI_W-1:0]           num_pri,
  output logic [1:0]                 TX_CLK,
  output logic                       RX_CLK,
  output logic [NUM_GATES-1:0]       DEMOD_ON,
  output logic                       RETRANSMIT,
  output logic                       busy,
  output logic                       frame_done,
  output logic [PRI_W-1:0]           pri_index
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    LISTEN = 2'd2,
    LAST   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DIV_W-1:0]   div, div_n;
  logic               phase, phase_n;
  logic [PRI_W-1:0]   idx_n;
  logic               busy_n, done_n, latch;

  // Shadow configuration: P and B are normalised once at frame start.
  logic [CNT_W-1:0]   sh_p, sh_b, p_n, b_n, p_in, b_in;
  logic [DIV_W-1:0]   sh_h, h_n;
  logic [PRI_W-1:0]   sh_np, np_n;

  logic [1:0]           tx_n;
  logic                 rx_n, rt_n;
  logic [NUM_GATES-1:0] demod_n;

  always_comb begin
    p_in = (pri_len < CNT_W'(2)) ? CNT_W'(2) : pri_len;
    b_in = (burst_len > (p_in - CNT_W'(1))) ? (p_in - CNT_W'(1)) : burst_len;
  end

  always_ff @(posedge coreClock or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div;
    phase_n = phase;
    idx_n   = pri_index;
    busy_n  = busy;
    done_n  = 1'b0;
    latch   = 1'b0;

    case (state)
      IDLE: begin
        if (start && ENABLE) begin
          latch   = 1'b1;
          cnt_n   = '0;
          div_n   = '0;
          phase_n = 1'b0;
          idx_n   = '0;
          busy_n  = 1'b1;
          state_n = (b_in == '0) ? LISTEN : BURST;
        end
      end
      BURST, LISTEN: begin
        cnt_n = cnt + CNT_W'(1);
        if (div == sh_h) begin
          div_n   = '0;
          phase_n = ~phase;
        end else begin
          div_n = div + DIV_W'(1);
        end
        if (state == BURST) begin
          if (cnt == sh_b - CNT_W'(1)) begin
            state_n = (sh_b == sh_p - CNT_W'(1)) ? LAST : LISTEN;
          end
        end else if (cnt == sh_p - CNT_W'(2)) begin
          state_n = LAST;
        end
      end
      LAST: begin
        cnt_n   = '0;
        div_n   = '0;
        phase_n = 1'b0;
        if ((sh_np == '0) || (pri_index != sh_np - PRI_W'(1))) begin
          idx_n   = pri_index + PRI_W'(1);
          state_n = (sh_b == '0) ? LISTEN : BURST;
        end else begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort overrides everything, including a frame that would finish this cycle.
    if (!ENABLE && (state != IDLE)) begin
      state_n = IDLE;
      cnt_n   = '0;
      div_n   = '0;
      phase_n = 1'b0;
      idx_n   = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end

    p_n  = latch ? p_in     : sh_p;
    b_n  = latch ? b_in     : sh_b;
    h_n  = latch ? half_div : sh_h;
    np_n = latch ? num_pri  : sh_np;
  end

  always_ff @(posedge coreClock or posedge RESET) begin
    if (RESET) begin
      cnt   <= '0;
      div   <= '0;
      phase <= 1'b0;
      sh_p  <= CNT_W'(2);
      sh_b  <= '0;
      sh_h  <= '0;
      sh_np <= '0;
    end else begin
      cnt   <= cnt_n;
      div   <= div_n;
      phase <= phase_n;
      sh_p  <= p_n;
      sh_b  <= b_n;
      sh_h  <= h_n;
      sh_np <= np_n;
    end
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    logic [CNT_W-1:0] gs, gs_n;
    logic [CNT_W:0]   ge, ge_n;

    assign gs_n = latch ? gate_start[g*CNT_W +: CNT_W] : gs;
    assign ge_n = latch ? ({1'b0, gate_start[g*CNT_W +: CNT_W]} + {1'b0, gate_len[g*CNT_W +: CNT_W]}) : ge;

    always_ff @(posedge coreClock or posedge RESET) begin
      if (RESET) begin
        gs <= '0;
        ge <= '0;
      end else begin
        gs <= gs_n;
        ge <= ge_n;
      end
    end

    assign demod_n[g] = busy_n && ({1'b0, cnt_n} >= {1'b0, gs_n}) && ({1'b0, cnt_n} < ge_n)
                        && (cnt_n <= p_n - CNT_W'(2));
  end

  // Outputs are derived from next-state values so they line up with cnt in the same cycle.
  always_comb begin
    rx_n = busy_n && (div_n == '0);
    rt_n = (state_n == LAST);
    tx_n = (state_n == BURST) ? {~phase_n, phase_n} : 2'b10;
`ifdef TX_DEADTIME_EN
    if ((h_n != '0) &&
        (((state_n == BURST) && (div_n == '0)) ||
         ((state == BURST) && ((state_n == LISTEN) || (state_n == LAST))))) begin
      tx_n = 2'b00;
    end
`endif
  end

  always_ff @(posedge coreClock or posedge RESET) begin
    if (RESET) begin
      TX_CLK     <= 2'b10;
      RX_CLK     <= 1'b0;
      DEMOD_ON   <= '0;
      RETRANSMIT <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pri_index  <= '0;
    end else begin
      TX_CLK     <= tx_n;
      RX_CLK     <= rx_n;
      DEMOD_ON   <= demod_n;
      RETRANSMIT <= rt_n;
      busy       <= busy_n;
      frame_done <= done_n;
      pri_index  <= idx_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_doppler_pri_sequencer.sv
// Self-checking bench for doppler_pri_sequencer: frame-level reference model plus directed pins.
`default_nettype none

module tb_doppler_pri_sequencer;

  localparam int CNT_W = 16;
  localparam int DIV_W = 4;
  localparam int NG    = 2;
  localparam int PRI_W = 8;

  logic              coreClock = 1'b0;
  logic              RESET, ENABLE, start;
  logic [DIV_W-1:0]  half_div;
  logic [CNT_W-1:0]  burst_len, pri_len;
  logic [NG*CNT_W-1:0] gate_start, gate_len;
  logic [PRI_W-1:0]  num_pri;
  logic [1:0]        TX_CLK;
  logic              RX_CLK, RETRANSMIT, busy, frame_done;
  logic [NG-1:0]     DEMOD_ON;
  logic [PRI_W-1:0]  pri_index;

  doppler_pri_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .NUM_GATES(NG), .PRI_W(PRI_W)) dut (
    .coreClock(coreClock), .RESET(RESET), .ENABLE(ENABLE), .start(start),
    .half_div(half_div), .burst_len(burst_len), .pri_len(pri_len),
    .gate_start(gate_start), .gate_len(gate_len), .num_pri(num_pri),
    .TX_CLK(TX_CLK), .RX_CLK(RX_CLK), .DEMOD_ON(DEMOD_ON), .RETRANSMIT(RETRANSMIT),
    .busy(busy), .frame_done(frame_done), .pri_index(pri_index)
  );

  always #5 coreClock = ~coreClock;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame model: elapsed cycles since frame start determine everything.
  int m_busy = 0, m_fd = 0, m_idx = 0, m_k = 0;
  int m_P = 2, m_B = 0, m_h = 0, m_np = 0;
  int m_gs [NG];
  int m_gl [NG];

  initial forever begin
    @(posedge coreClock or posedge RESET);
    if (RESET) begin
      m_busy = 0; m_fd = 0; m_idx = 0; m_k = 0;
    end else begin
      m_fd = 0;
      if (m_busy != 0) begin
        if (!ENABLE) begin
          m_busy = 0; m_idx = 0;
        end else begin
          m_k++;
          if (m_np != 0 && m_k == m_np * m_P) begin
            m_busy = 0; m_fd = 1;
          end else begin
            m_idx = (m_k / m_P) % 256;
          end
        end
      end else if (start && ENABLE) begin
        m_P  = (int'(pri_len) < 2) ? 2 : int'(pri_len);
        m_B  = (int'(burst_len) > m_P - 1) ? m_P - 1 : int'(burst_len);
        m_h  = int'(half_div);
        m_np = int'(num_pri);
        for (int g = 0; g < NG; g++) begin
          m_gs[g] = int'(gate_start[g*CNT_W +: CNT_W]);
          m_gl[g] = int'(gate_len[g*CNT_W +: CNT_W]);
        end
        m_busy = 1; m_k = 0; m_idx = 0;
      end
    end
  end

  initial forever begin
    int c, per, ph;
    logic [1:0] e_tx;
    logic e_rx, e_rt;
    logic [NG-1:0] e_dm;
    @(posedge coreClock);
    #1;
    e_tx = 2'b10; e_rx = 1'b0; e_rt = 1'b0; e_dm = '0;
    if (m_busy != 0) begin
      c   = m_k % m_P;
      per = m_h + 1;
      e_rx = (c % per) == 0;
      e_rt = (c == m_P - 1);
      for (int g = 0; g < NG; g++)
        e_dm[g] = (c >= m_gs[g]) && (c < m_gs[g] + m_gl[g]) && (c <= m_P - 2);
      if (c < m_B) begin
        ph = (c / per) % 2;
        e_tx = (ph != 0) ? 2'b01 : 2'b10;
`ifdef TX_DEADTIME_EN
        if (m_h >= 1 && (c % per) == 0) e_tx = 2'b00;
`endif
      end else begin
`ifdef TX_DEADTIME_EN
        if (m_h >= 1 && m_B > 0 && c == m_B) e_tx = 2'b00;
`endif
      end
    end
    check("tx_clk",     32'(TX_CLK),     32'(e_tx));
    check("rx_clk",     32'(RX_CLK),     32'(e_rx));
    check("demod_on",   32'(DEMOD_ON),   32'(e_dm));
    check("retransmit", 32'(RETRANSMIT), 32'(e_rt));
    check("busy",       32'(busy),       32'(m_busy != 0));
    check("frame_done", 32'(frame_done), 32'(m_fd != 0));
    check("pri_index",  32'(pri_index),  32'(m_idx));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge coreClock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  logic [7:0]  tx0_seq;
  logic [15:0] d0_seq, d1_seq, tx_seq;
  int          tx_active;

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; start = 1'b0; half_div = '0; burst_len = '0; pri_len = '0;
    gate_start = '0; gate_len = '0; num_pri = '0;
    repeat (3) @(posedge coreClock);
    #1;
    RESET = 1'b0;
    check("rst_tx", 32'(TX_CLK), 32'h2);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx", 32'(pri_index), 0);
    tick(2);

    // Two-PRI frame with TX period 4
    half_div = 4'd1; burst_len = 16'd8; pri_len = 16'd20; num_pri = 8'd2;
    gate_start = {16'd0, 16'd2}; gate_len = {16'd0, 16'd4};
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tx0_seq[i] = TX_CLK[0];
      tick(1);
    end
`ifndef TX_DEADTIME_EN
    check("t1_tx0_seq", 32'(tx0_seq), 32'h00CC);
`endif
    tick(11);
    check("t1_rt_pri0", 32'(RETRANSMIT), 1);
    tick(20);
    check("t1_rt_pri1", 32'(RETRANSMIT), 1);
    check("t1_idx_pri1", 32'(pri_index), 1);
    tick(1);
    check("t1_frame_done", 32'(frame_done), 1);
    check("t1_busy_low", 32'(busy), 0);
    tick(2);

    // Two overlapping gates, second one clipped at P-2
    half_div = 4'd0; burst_len = 16'd4; pri_len = 16'd16; num_pri = 8'd1;
    gate_start = {16'd6, 16'd5}; gate_len = {16'd20, 16'd3};
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      d0_seq[i] = DEMOD_ON[0];
      d1_seq[i] = DEMOD_ON[1];
      tick(1);
    end
    check("t2_gate0", 32'(d0_seq), 32'h00E0);
    check("t2_gate1", 32'(d1_seq), 32'h7FC0);
    tick(2);

    // No burst at all
    half_div = 4'd1; burst_len = 16'd0; pri_len = 16'd10; num_pri = 8'd1;
    pulse_start();
    tx_active = 0;
    for (int i = 0; i < 10; i++) begin
      if (TX_CLK !== 2'b10) tx_active++;
      tick(1);
    end
    check("t3_no_tx", 32'(tx_active), 0);
    tick(2);

    // Burst longer than the PRI is clipped to P-1
    burst_len = 16'd40;
    pulse_start();
    tick(9);
`ifdef TX_DEADTIME_EN
    check("t3_tx_cnt9", 32'(TX_CLK), 32'h0);
`else
    check("t3_tx_cnt9", 32'(TX_CLK), 32'h2);
`endif
    check("t3_rt_cnt9", 32'(RETRANSMIT), 1);
    tick(3);

    // Continuous mode, index wrap, abort mid-burst
    half_div = 4'd0; burst_len = 16'd1; pri_len = 16'd2; num_pri = 8'd0;
    pulse_start();
    tick(510);
    check("t4_idx_255", 32'(pri_index), 255);
    tick(2);
    check("t4_idx_wrap", 32'(pri_index), 0);
    check("t4_busy_wrap", 32'(busy), 1);
    ENABLE = 1'b0;
    tick(1);
    check("t4_abort_tx", 32'(TX_CLK), 32'h2);
    check("t4_abort_busy", 32'(busy), 0);
    ENABLE = 1'b1;
    tick(1);
    ENABLE = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0; ENABLE = 1'b1;
    check("t4_start_disabled", 32'(busy), 0);
    tick(2);

    // Start while busy is ignored; async reset mid-LISTEN
    half_div = 4'd1; burst_len = 16'd4; pri_len = 16'd30; num_pri = 8'd3;
    pulse_start();
    tick(3);
    pri_len = 16'd5;
    pulse_start();
    tick(26);
    check("t5_idx_pri1", 32'(pri_index), 1);
    check("t5_busy_pri1", 32'(busy), 1);
    tick(10);
    #2;
    RESET = 1'b1;
    #1;
    check("t5_rst_tx", 32'(TX_CLK), 32'h2);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_idx", 32'(pri_index), 0);
    check("t5_rst_demod", 32'(DEMOD_ON), 0);
    @(posedge coreClock);
    #1;
    RESET = 1'b0;
    tick(2);

    // TX sequence with half_div=2
    half_div = 4'd2; burst_len = 16'd8; pri_len = 16'd12; num_pri = 8'd1;
    gate_start = '0; gate_len = '0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tx_seq[2*i +: 2] = TX_CLK;
      tick(1);
    end
`ifdef TX_DEADTIME_EN
    check("t6_tx_seq", 32'(tx_seq), 32'h8528);
    check("t6_tx_exit", 32'(TX_CLK), 32'h0);
`else
    check("t6_tx_seq", 32'(tx_seq), 32'hA56A);
    check("t6_tx_exit", 32'(TX_CLK), 32'h2);
`endif
    tick(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
